// File: rtl/lookup_engine_tcam.sv
// Ternary match-action lookup stage: capture -> TCAM match -> action read, with global stall.
// Define LOOKUP_STATS_EN to add saturating hit_cnt / miss_cnt output ports.
module lookup_engine_tcam #(
    parameter int                 STAGE       = 0,
    parameter int                 PHV_LEN     = 48*8+32*8+16*8+5*20+256,
    parameter int                 KEY_LEN     = 197,
    parameter int                 ACT_LEN     = 625,
    parameter int                 DEPTH       = 16,
    parameter int                 ADDR_W      = $clog2(DEPTH),
    parameter logic [ACT_LEN-1:0] DEFAULT_ACT = ACT_LEN'('h3f)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [KEY_LEN-1:0] key_in,
    input  logic               key_valid,
    input  logic [PHV_LEN-1:0] phv_in,
    output logic               key_ready,
    output logic [ACT_LEN-1:0] action_out,
    output logic               action_hit,
    output logic [ADDR_W-1:0]  action_addr_out,
    output logic               action_valid,
    output logic [PHV_LEN-1:0] phv_out,
    input  logic               action_ready,
    input  logic               cam_wr_en,
    input  logic [ADDR_W-1:0]  cam_wr_addr,
    input  logic [KEY_LEN-1:0] cam_wr_key,
    input  logic [KEY_LEN-1:0] cam_wr_mask,
    input  logic               cam_wr_vld,
    input  logic               act_wr_en,
    input  logic [ADDR_W-1:0]  act_wr_addr,
    input  logic [ACT_LEN-1:0] act_wr_data
`ifdef LOOKUP_STATS_EN
    ,
    output logic [31:0]        hit_cnt,
    output logic [31:0]        miss_cnt
`endif
);

    if (DEPTH < 2 || DEPTH > 64 || (DEPTH & (DEPTH - 1)) != 0 || STAGE < 0) begin : g_bad_cfg
        $error("lookup_engine_tcam: DEPTH must be a power of two in 2..64 and STAGE >= 0");
    end

    // Handshake: a transfer happens on an edge where valid & ready; the whole pipe
    // advances when the output register is empty or being drained (adv).
    logic adv;
    assign adv       = ~action_valid | action_ready;
    assign key_ready = adv;

    logic [KEY_LEN-1:0] cam_key  [DEPTH];
    logic [KEY_LEN-1:0] cam_mask [DEPTH];
    logic [DEPTH-1:0]   cam_vld;
    logic [ACT_LEN-1:0] act_mem  [DEPTH];

    logic [KEY_LEN-1:0] k1;
    logic [PHV_LEN-1:0] phv1;
    logic               v1;
    logic               m2_hit;
    logic [ADDR_W-1:0]  m2_addr;
    logic [PHV_LEN-1:0] phv2;
    logic               v2;

    logic [DEPTH-1:0]   hit_vec;
    logic               hit_any;
    logic [ADDR_W-1:0]  hit_idx;

    // Control writes land regardless of stalls; reads see them from the next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            cam_vld <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                cam_key[i]  <= '0;
                cam_mask[i] <= '0;
                act_mem[i]  <= '0;
            end
        end else begin
            if (cam_wr_en) begin
                cam_key[cam_wr_addr]  <= cam_wr_key;
                cam_mask[cam_wr_addr] <= cam_wr_mask;
                cam_vld[cam_wr_addr]  <= cam_wr_vld;
            end
            if (act_wr_en) begin
                act_mem[act_wr_addr] <= act_wr_data;
            end
        end
    end

    always_comb begin
        hit_vec = '0;
        for (int i = 0; i < DEPTH; i++) begin
            hit_vec[i] = cam_vld[i] & (((k1 ^ cam_key[i]) & ~cam_mask[i]) == '0);
        end
    end

    // Scan downwards so the lowest matching index is the last one written.
    always_comb begin
        hit_any = |hit_vec;
        hit_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (hit_vec[i]) begin
                hit_idx = ADDR_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            k1              <= '0;
            phv1            <= '0;
            v1              <= 1'b0;
            m2_hit          <= 1'b0;
            m2_addr         <= '0;
            phv2            <= '0;
            v2              <= 1'b0;
            action_out      <= '0;
            action_hit      <= 1'b0;
            action_addr_out <= '0;
            phv_out         <= '0;
            action_valid    <= 1'b0;
        end else if (adv) begin
            k1              <= key_in;
            phv1            <= phv_in;
            v1              <= key_valid;
            m2_hit          <= hit_any;
            m2_addr         <= hit_idx;
            phv2            <= phv1;
            v2              <= v1;
            action_out      <= m2_hit ? act_mem[m2_addr] : DEFAULT_ACT;
            action_hit      <= m2_hit;
            action_addr_out <= m2_addr;
            phv_out         <= phv2;
            action_valid    <= v2;
        end
    end

`ifdef LOOKUP_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (action_valid && action_ready) begin
            if (action_hit) begin
                if (hit_cnt != 32'hFFFF_FFFF) hit_cnt <= hit_cnt + 32'd1;
            end else begin
                if (miss_cnt != 32'hFFFF_FFFF) miss_cnt <= miss_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_lookup_engine_tcam.sv
// Directed bench for lookup_engine_tcam: vector table plus stall, collision and reset sequences.
// Also checks hit_cnt / miss_cnt when built with LOOKUP_STATS_EN.
module tb_lookup_engine_tcam;

    localparam int PHV_LEN = 48*8+32*8+16*8+5*20+256;
    localparam int KEY_LEN = 197;
    localparam int ACT_LEN = 625;
    localparam int DEPTH   = 16;
    localparam int ADDR_W  = $clog2(DEPTH);
    localparam int W       = PHV_LEN;
    localparam logic [ACT_LEN-1:0] DEF_ACT = ACT_LEN'('h3f);

    logic               clk = 1'b0;
    logic               rst;
    logic [KEY_LEN-1:0] key_in;
    logic               key_valid;
    logic [PHV_LEN-1:0] phv_in;
    logic               key_ready;
    logic [ACT_LEN-1:0] action_out;
    logic               action_hit;
    logic [ADDR_W-1:0]  action_addr_out;
    logic               action_valid;
    logic [PHV_LEN-1:0] phv_out;
    logic               action_ready;
    logic               cam_wr_en;
    logic [ADDR_W-1:0]  cam_wr_addr;
    logic [KEY_LEN-1:0] cam_wr_key;
    logic [KEY_LEN-1:0] cam_wr_mask;
    logic               cam_wr_vld;
    logic               act_wr_en;
    logic [ADDR_W-1:0]  act_wr_addr;
    logic [ACT_LEN-1:0] act_wr_data;
`ifdef LOOKUP_STATS_EN
    logic [31:0]        hit_cnt;
    logic [31:0]        miss_cnt;
`endif

    lookup_engine_tcam dut (
        .clk(clk), .rst(rst),
        .key_in(key_in), .key_valid(key_valid), .phv_in(phv_in), .key_ready(key_ready),
        .action_out(action_out), .action_hit(action_hit), .action_addr_out(action_addr_out),
        .action_valid(action_valid), .phv_out(phv_out), .action_ready(action_ready),
        .cam_wr_en(cam_wr_en), .cam_wr_addr(cam_wr_addr), .cam_wr_key(cam_wr_key),
        .cam_wr_mask(cam_wr_mask), .cam_wr_vld(cam_wr_vld),
        .act_wr_en(act_wr_en), .act_wr_addr(act_wr_addr), .act_wr_data(act_wr_data)
`ifdef LOOKUP_STATS_EN
        , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [KEY_LEN-1:0] key;
        logic [PHV_LEN-1:0] phv;
        logic               hit;
        logic [ADDR_W-1:0]  addr;
        logic [ACT_LEN-1:0] act;
    } vec_t;

    int   n_vec = 0;
    int   n_err = 0;
    vec_t vecs[7];
    vec_t bp[4];
    vec_t exp_q[$];

`ifdef LOOKUP_STATS_EN
    int m_hit = 0;
    int m_miss = 0;
    always @(posedge clk) begin
        if (rst) begin
            m_hit  = 0;
            m_miss = 0;
        end else if (action_valid && action_ready) begin
            if (action_hit) m_hit = m_hit + 1;
            else            m_miss = m_miss + 1;
        end
    end
`endif

    function automatic vec_t mk(input logic [KEY_LEN-1:0] k, input logic [PHV_LEN-1:0] p,
                                input logic h, input int a, input logic [ACT_LEN-1:0] act);
        vec_t v;
        v.key = k; v.phv = p; v.hit = h; v.addr = ADDR_W'(a); v.act = act;
        return v;
    endfunction

    task automatic check(input string nm, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, got[127:0], exp[127:0]);
        end
    endtask

    task automatic cam_write(input int a, input logic [KEY_LEN-1:0] k,
                             input logic [KEY_LEN-1:0] m, input logic v);
        @(posedge clk); #1;
        cam_wr_en = 1'b1; cam_wr_addr = ADDR_W'(a);
        cam_wr_key = k; cam_wr_mask = m; cam_wr_vld = v;
        @(posedge clk); #1;
        cam_wr_en = 1'b0;
    endtask

    task automatic act_write(input int a, input logic [ACT_LEN-1:0] d);
        @(posedge clk); #1;
        act_wr_en = 1'b1; act_wr_addr = ADDR_W'(a); act_wr_data = d;
        @(posedge clk); #1;
        act_wr_en = 1'b0;
    endtask

    // Presents one key; optionally writes act[5] in the cycle the result is read from memory.
    task automatic lookup(input logic [KEY_LEN-1:0] k, input logic [PHV_LEN-1:0] p,
                          input bit wr, input logic [ACT_LEN-1:0] wdata, output int lat);
        @(posedge clk); #1;
        key_in = k; phv_in = p; key_valid = 1'b1; action_ready = 1'b1;
        lat = -1;
        for (int e = 1; e <= 10; e++) begin
            @(posedge clk); #1;
            key_valid = 1'b0;
            act_wr_en = 1'b0;
            if (action_valid) begin
                lat = e;
                break;
            end
            if (wr && e == 2) begin
                act_wr_en = 1'b1; act_wr_addr = ADDR_W'(5); act_wr_data = wdata;
            end
        end
    endtask

    task automatic apply_vec(input string nm, input vec_t v, input bit wr,
                             input logic [ACT_LEN-1:0] wdata);
        int lat;
        lookup(v.key, v.phv, wr, wdata, lat);
        check({nm, "_latency"}, W'(lat), W'(3));
        check({nm, "_hit"}, W'(action_hit), W'(v.hit));
        check({nm, "_addr"}, W'(action_addr_out), W'(v.addr));
        check({nm, "_act"}, W'(action_out), W'(v.act));
        check({nm, "_phv"}, phv_out, v.phv);
    endtask

    initial begin
        int   p, got, stall_left, quiet;
        bit   accept;
        vec_t e;
        logic [ACT_LEN+PHV_LEN+ADDR_W+1:0] snap;

        rst = 1'b1; key_in = '0; key_valid = 1'b0; phv_in = '0; action_ready = 1'b0;
        cam_wr_en = 1'b0; cam_wr_addr = '0; cam_wr_key = '0; cam_wr_mask = '0; cam_wr_vld = 1'b0;
        act_wr_en = 1'b0; act_wr_addr = '0; act_wr_data = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        check("rst_valid", W'(action_valid), W'(0));
        check("rst_hit", W'(action_hit), W'(0));
        check("rst_addr", W'(action_addr_out), W'(0));
        check("rst_act", W'(action_out), W'(0));
        check("rst_phv", phv_out, W'(0));
        check("rst_key_ready", W'(key_ready), W'(1));

        apply_vec("empty_miss", mk(KEY_LEN'(1), W'('hA5), 1'b0, 0, DEF_ACT), 1'b0, '0);

        cam_write(5, KEY_LEN'('h1234), '0, 1'b1);
        act_write(5, ACT_LEN'('hBEEF));
        cam_write(2, KEY_LEN'('h10), KEY_LEN'('hF), 1'b1);
        cam_write(7, KEY_LEN'('h1A), '0, 1'b1);
        act_write(2, ACT_LEN'('h2222));
        act_write(7, ACT_LEN'('h7777));

        vecs[0] = mk(KEY_LEN'('h1234), W'('h11), 1'b1, 5, ACT_LEN'('hBEEF));
        vecs[1] = mk(KEY_LEN'('h1235), W'('h12), 1'b0, 0, DEF_ACT);
        vecs[2] = mk(KEY_LEN'('h1A),   W'('h13), 1'b1, 2, ACT_LEN'('h2222));
        vecs[3] = mk(KEY_LEN'('h10),   W'('h14), 1'b1, 2, ACT_LEN'('h2222));
        vecs[4] = mk(KEY_LEN'('h1F),   W'('h15), 1'b1, 2, ACT_LEN'('h2222));
        vecs[5] = mk(KEY_LEN'('h20),   W'('h16), 1'b0, 0, DEF_ACT);
        vecs[6] = mk(KEY_LEN'(0),      W'('h17), 1'b0, 0, DEF_ACT);
        for (int i = 0; i < 7; i++) begin
            apply_vec($sformatf("vec%0d", i), vecs[i], 1'b0, '0);
        end

        cam_write(2, KEY_LEN'('h10), KEY_LEN'('hF), 1'b0);
        apply_vec("invalidated", mk(KEY_LEN'('h1A), W'('h21), 1'b1, 7, ACT_LEN'('h7777)), 1'b0, '0);

        // Backpressure: four back-to-back keys, first output held for five cycles.
        bp[0] = mk(KEY_LEN'('h1234), W'('hB0), 1'b1, 5, ACT_LEN'('hBEEF));
        bp[1] = mk(KEY_LEN'('h1A),   W'('hB1), 1'b1, 7, ACT_LEN'('h7777));
        bp[2] = mk(KEY_LEN'('h99),   W'('hB2), 1'b0, 0, DEF_ACT);
        bp[3] = mk(KEY_LEN'('h1234), W'('hB3), 1'b1, 5, ACT_LEN'('hBEEF));
        @(posedge clk); #1;
        key_valid = 1'b0; action_ready = 1'b1;
        p = 0; got = 0; stall_left = 5; snap = '0;
        for (int cyc = 0; cyc < 60 && got < 4; cyc++) begin
            @(negedge clk);
            if (action_valid && stall_left > 0) begin
                action_ready = 1'b0;
                if (stall_left == 5) snap = {action_valid, action_hit, action_addr_out, action_out, phv_out};
            end else begin
                action_ready = 1'b1;
            end
            key_valid = (p < 4);
            if (p < 4) begin
                key_in = bp[p].key; phv_in = bp[p].phv;
            end
            #1;
            if (!action_ready) begin
                check("bp_key_ready", W'(key_ready), W'(0));
                if (stall_left < 5)
                    check("bp_hold", W'({action_valid, action_hit, action_addr_out, action_out, phv_out} != snap), W'(0));
                stall_left--;
            end
            if (action_valid && action_ready) begin
                if (exp_q.size() == 0) begin
                    check("bp_unexpected_output", W'(1), W'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("bp_phv", phv_out, e.phv);
                    check("bp_hit", W'(action_hit), W'(e.hit));
                    check("bp_addr", W'(action_addr_out), W'(e.addr));
                    check("bp_act", W'(action_out), W'(e.act));
                end
                got++;
            end
            accept = key_valid && key_ready;
            @(posedge clk);
            if (accept) begin
                exp_q.push_back(bp[p]);
                p++;
            end
        end
        #1 key_valid = 1'b0;
        check("bp_count", W'(got), W'(4));
        quiet = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (action_valid) quiet++;
        end
        check("bp_no_dup", W'(quiet), W'(0));

        apply_vec("collision_old", mk(KEY_LEN'('h1234), W'('hC0), 1'b1, 5, ACT_LEN'('hBEEF)), 1'b1, ACT_LEN'('hCAFE));
        apply_vec("collision_new", mk(KEY_LEN'('h1234), W'('hC1), 1'b1, 5, ACT_LEN'('hCAFE)), 1'b0, '0);

        act_write(0, ACT_LEN'('hA0A0));
        cam_write(0, KEY_LEN'('h55), '1, 1'b0);
        apply_vec("wildcard_invalid", mk(KEY_LEN'('h55), W'('hD0), 1'b0, 0, DEF_ACT), 1'b0, '0);
        cam_write(0, KEY_LEN'('h55), '1, 1'b1);
        apply_vec("wildcard_valid", mk(KEY_LEN'('h1234), W'('hD1), 1'b1, 0, ACT_LEN'('hA0A0)), 1'b0, '0);

        // Mid-stream reset: two keys in flight are discarded.
        @(posedge clk); #1;
`ifdef LOOKUP_STATS_EN
        check("stats_hit_pre", W'(hit_cnt), W'(m_hit));
        check("stats_miss_pre", W'(miss_cnt), W'(m_miss));
`endif
        key_in = KEY_LEN'('h1234); phv_in = W'('hE0); key_valid = 1'b1; action_ready = 1'b1;
        @(posedge clk); #1;
        phv_in = W'('hE1);
        @(posedge clk); #1;
        key_valid = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_valid", W'(action_valid), W'(0));
        check("midrst_act", W'(action_out), W'(0));
        check("midrst_hit", W'(action_hit), W'(0));
`ifdef LOOKUP_STATS_EN
        check("stats_hit_rst", W'(hit_cnt), W'(0));
        check("stats_miss_rst", W'(miss_cnt), W'(0));
`endif
        rst = 1'b0;
        quiet = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (action_valid) quiet++;
        end
        check("midrst_discard", W'(quiet), W'(0));
        apply_vec("post_rst_miss", mk(KEY_LEN'('h1234), W'('hF0), 1'b0, 0, DEF_ACT), 1'b0, '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
